// File: rtl/cu_pkg.sv
// cu_pkg
// Shared definitions for the control unit: opcode constants, the FSM state
// enum with its fixed debug encodings, ALU operation codes and the opcode
// classes produced by the decoder.
package cu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Encodings are visible on the debug state port, so they are pinned here.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_FETCH_RD = 4'd1,
    S_FETCH_IR = 4'd2,
    S_DECODE   = 4'd3,
    S_EXEC     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  // Undefined opcodes decode as CLS_NOP with the illegal flag raised.
  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_LOAD  = 3'd1,
    CLS_STORE = 3'd2,
    CLS_ALU   = 3'd3,
    CLS_JMP   = 3'd4,
    CLS_JZ    = 3'd5,
    CLS_HALT  = 3'd6
  } op_class_t;

endpackage

// File: rtl/cu_decoder.sv
// cu_decoder
// Purely combinational opcode decoder.
// Ports:
//   opcode   - opcode field of the instruction register
//   op_class - what kind of instruction this is (drives FSM branching)
//   alu_op   - ALU function for ALU-class opcodes, ADD otherwise
//   illegal  - high for undefined opcodes
module cu_decoder
  import cu_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opcode,
  output op_class_t        op_class,
  output alu_op_t          alu_op,
  output logic             illegal
);

  // Map each opcode onto its class; anything unlisted is illegal and
  // behaves like a NOP.
  always_comb begin
    op_class = CLS_NOP;
    alu_op   = ALU_ADD;
    illegal  = 1'b0;
    case (opcode)
      OPC_W'(OP_NOP):   op_class = CLS_NOP;
      OPC_W'(OP_LOAD):  op_class = CLS_LOAD;
      OPC_W'(OP_STORE): op_class = CLS_STORE;
      OPC_W'(OP_ADD):   begin op_class = CLS_ALU; alu_op = ALU_ADD; end
      OPC_W'(OP_SUB):   begin op_class = CLS_ALU; alu_op = ALU_SUB; end
      OPC_W'(OP_AND):   begin op_class = CLS_ALU; alu_op = ALU_AND; end
      OPC_W'(OP_OR):    begin op_class = CLS_ALU; alu_op = ALU_OR;  end
      OPC_W'(OP_JMP):   op_class = CLS_JMP;
      OPC_W'(OP_JZ):    op_class = CLS_JZ;
      OPC_W'(OP_HALT):  op_class = CLS_HALT;
      default:          illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit
// Multi-cycle FSM sequencing fetch, decode, ALU execute and memory access
// for a small accumulator-style CPU. State is registered; every strobe is
// decoded combinationally from the current state and the opcode.
// Optional feature: define CU_STEP_EN to add a single-step input that holds
// the machine in FETCH until step is high.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   step          - (CU_STEP_EN only) advance out of FETCH when high
//   instr         - instruction register contents
//   alu_zero      - ALU zero result, captured in EXEC
//   mar_load/sel  - MAR load strobe and source (0=PC, 1=instr[7:0])
//   ram_rd_en     - RAM read enable
//   ram_write_en  - RAM write strobe
//   ir_load       - instruction register load
//   pc_inc/load   - PC increment / load from instr[7:0]
//   alu_op        - ALU function
//   rf_write_en   - register file write, rf_wsel picks ALU(0) or RAM(1)
//   illegal       - one-cycle pulse on an undefined opcode
//   halted        - high while in HALT
//   state         - current state encoding for debug
module control_unit
  import cu_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
`ifdef CU_STEP_EN
  input  logic               step,
`endif
  input  logic [INSTR_W-1:0] instr,
  input  logic               alu_zero,
  output logic               mar_load,
  output logic               mar_sel,
  output logic               ram_rd_en,
  output logic               ram_write_en,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_load,
  output logic [1:0]         alu_op,
  output logic               rf_write_en,
  output logic               rf_wsel,
  output logic               illegal,
  output logic               halted,
  output logic [3:0]         state
);

  state_t     state_q;
  logic       zero_flag;
  op_class_t  dec_class;
  alu_op_t    dec_alu_op;
  logic       dec_illegal;
  logic       fetch_go;

  // Operand bits are consumed by the datapath, not by the controller.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[INSTR_W-OPC_W-1:0];

  cu_decoder #(.OPC_W(OPC_W)) u_decoder (
    .opcode   (instr[INSTR_W-1 -: OPC_W]),
    .op_class (dec_class),
    .alu_op   (dec_alu_op),
    .illegal  (dec_illegal)
  );

`ifdef CU_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  // State register and zero flag. The flag is only captured in EXEC so a
  // later JZ tests the result of the last ALU instruction, not whatever the
  // ALU happens to output at decode time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      zero_flag <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:    if (fetch_go) state_q <= S_FETCH_RD;
        S_FETCH_RD: state_q <= S_FETCH_IR;
        S_FETCH_IR: state_q <= S_DECODE;
        S_DECODE: begin
          case (dec_class)
            CLS_ALU:             state_q <= S_EXEC;
            CLS_LOAD, CLS_STORE: state_q <= S_MEM_ADDR;
            CLS_HALT:            state_q <= S_HALT;
            default:             state_q <= S_FETCH;
          endcase
        end
        S_EXEC: begin
          zero_flag <= alu_zero;
          state_q   <= S_FETCH;
        end
        S_MEM_ADDR: begin
          case (dec_class)
            CLS_LOAD:  state_q <= S_MEM_RD;
            CLS_STORE: state_q <= S_MEM_WR;
            default:   state_q <= S_FETCH;
          endcase
        end
        S_MEM_RD:   state_q <= S_MEM_WB;
        S_MEM_WB:   state_q <= S_FETCH;
        S_MEM_WR:   state_q <= S_FETCH;
        S_HALT:     state_q <= S_HALT;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // Strobe decode. Reset masks everything immediately so an in-flight
  // RAM write is cancelled in the same cycle reset is raised.
  always_comb begin
    mar_load     = 1'b0;
    mar_sel      = 1'b0;
    ram_rd_en    = 1'b0;
    ram_write_en = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    alu_op       = ALU_ADD;
    rf_write_en  = 1'b0;
    rf_wsel      = 1'b0;
    illegal      = 1'b0;
    halted       = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH:    mar_load = 1'b1;
        S_FETCH_RD: ram_rd_en = 1'b1;
        S_FETCH_IR: begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
        S_DECODE: begin
          illegal = dec_illegal;
          case (dec_class)
            CLS_JMP: pc_load = 1'b1;
            CLS_JZ:  pc_load = zero_flag;
            default: pc_load = 1'b0;
          endcase
        end
        S_EXEC: begin
          alu_op      = dec_alu_op;
          rf_write_en = 1'b1;
        end
        S_MEM_ADDR: begin
          mar_sel  = 1'b1;
          mar_load = 1'b1;
        end
        S_MEM_RD:   ram_rd_en = 1'b1;
        S_MEM_WB: begin
          rf_write_en = 1'b1;
          rf_wsel     = 1'b1;
        end
        S_MEM_WR:   ram_write_en = 1'b1;
        S_HALT:     halted = 1'b1;
        default:    halted = 1'b0;
      endcase
    end
  end

  assign state = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Drives directed and random instruction streams into control_unit and
// compares state and strobes each cycle against a per-instruction trace
// built from the opcode rules.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        alu_zero = 1'b0;
`ifdef CU_STEP_EN
  logic        step = 1'b1;
`endif
  logic        mar_load, mar_sel, ram_rd_en, ram_write_en, ir_load, pc_inc;
  logic        pc_load, rf_write_en, rf_wsel, illegal, halted;
  logic [1:0]  alu_op;
  logic [3:0]  state;

  typedef struct packed {
    logic       mar_load;
    logic       mar_sel;
    logic       ram_rd_en;
    logic       ram_write_en;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic [1:0] alu_op;
    logic       rf_write_en;
    logic       rf_wsel;
    logic       illegal;
    logic       halted;
  } outs_t;

  typedef struct {
    logic [3:0] st;
    outs_t      o;
  } exp_t;

  exp_t trace[$];
  int   assertCount = 0;
  int   failCount = 0;
  logic modelZf = 1'b0;

  control_unit dut (
    .clk          (clk),
    .rst          (rst),
`ifdef CU_STEP_EN
    .step         (step),
`endif
    .instr        (instr),
    .alu_zero     (alu_zero),
    .mar_load     (mar_load),
    .mar_sel      (mar_sel),
    .ram_rd_en    (ram_rd_en),
    .ram_write_en (ram_write_en),
    .ir_load      (ir_load),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .alu_op       (alu_op),
    .rf_write_en  (rf_write_en),
    .rf_wsel      (rf_wsel),
    .illegal      (illegal),
    .halted       (halted),
    .state        (state)
  );

  always #5 clk = ~clk;

  // One cycle of inputs, applied on the falling edge; outputs settle #1 later.
  task automatic applyStimulus(input logic r, input logic [15:0] w, input logic z);
    @(negedge clk);
    rst      = r;
    instr    = w;
    alu_zero = z;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expSt, input outs_t expO);
    outs_t obs;
    obs = {mar_load, mar_sel, ram_rd_en, ram_write_en, ir_load, pc_inc, pc_load,
           alu_op, rf_write_en, rf_wsel, illegal, halted};
    assertCount++;
    assert (state === expSt) else begin
      failCount++;
      $error("[TB] FAIL %s state: got %0d expected %0d", tag, state, expSt);
    end
    assertCount++;
    assert (obs === expO) else begin
      failCount++;
      $error("[TB] FAIL %s strobes: got %b expected %b", tag, obs, expO);
    end
  endtask

  // Expected per-cycle trace of one instruction, from fetch to its last state.
  task automatic buildTrace(input logic [3:0] opc, input logic zf);
    exp_t e;
    trace.delete();
    e.st = 4'd0; e.o = '0; e.o.mar_load = 1'b1; trace.push_back(e);
    e.st = 4'd1; e.o = '0; e.o.ram_rd_en = 1'b1; trace.push_back(e);
    e.st = 4'd2; e.o = '0; e.o.ir_load = 1'b1; e.o.pc_inc = 1'b1; trace.push_back(e);
    e.st = 4'd3; e.o = '0;
    if (opc == 4'h7) e.o.pc_load = 1'b1;
    if (opc == 4'h8) e.o.pc_load = zf;
    if (opc >= 4'h9 && opc <= 4'hE) e.o.illegal = 1'b1;
    trace.push_back(e);
    if (opc >= 4'h3 && opc <= 4'h6) begin
      e.st = 4'd4; e.o = '0; e.o.alu_op = 2'(opc - 4'h3); e.o.rf_write_en = 1'b1;
      trace.push_back(e);
    end
    if (opc == 4'h1 || opc == 4'h2) begin
      e.st = 4'd5; e.o = '0; e.o.mar_sel = 1'b1; e.o.mar_load = 1'b1; trace.push_back(e);
      if (opc == 4'h1) begin
        e.st = 4'd6; e.o = '0; e.o.ram_rd_en = 1'b1; trace.push_back(e);
        e.st = 4'd7; e.o = '0; e.o.rf_write_en = 1'b1; e.o.rf_wsel = 1'b1; trace.push_back(e);
      end else begin
        e.st = 4'd8; e.o = '0; e.o.ram_write_en = 1'b1; trace.push_back(e);
      end
    end
    if (opc == 4'hF) begin
      e.st = 4'd9; e.o = '0; e.o.halted = 1'b1; trace.push_back(e);
    end
  endtask

  // Runs one instruction. zmode<0 randomizes alu_zero, else forces it.
  // cut>=0 raises reset in that cycle; cut==-2 picks a random cycle.
  task automatic runInstr(input string tag, input logic [15:0] w, input int zmode, input int cut);
    logic pendZf;
    logic z;
    int   cutAt;
    buildTrace(w[15:12], modelZf);
    pendZf = modelZf;
    cutAt  = (cut == -2) ? int'($urandom_range(0, trace.size() - 1)) : cut;
    foreach (trace[i]) begin
      z = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
      if (i == cutAt) begin
        applyStimulus(1'b1, w, z);
        checkOutput($sformatf("%s rst@%0d", tag, i), 4'd0, '0);
        modelZf = 1'b0;
        return;
      end
      applyStimulus(1'b0, w, z);
      checkOutput($sformatf("%s cyc%0d", tag, i), trace[i].st, trace[i].o);
      if (trace[i].st == 4'd4) pendZf = z;
    end
    modelZf = pendZf;
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
      checkOutput("reset", 4'd0, '0);
    end
    modelZf = 1'b0;
  endtask

  initial begin
    outs_t haltO;
    logic [15:0] w;
    haltO = '0;
    haltO.halted = 1'b1;

    doReset(3);

    runInstr("add", 16'h3ABC, 1, -1);
    runInstr("load", 16'h1042, -1, -1);
    runInstr("sub z0", 16'h4123, 0, -1);
    runInstr("jz nz", 16'h8010, -1, -1);
    runInstr("sub z1", 16'h4321, 1, -1);
    runInstr("jz z", 16'h8010, -1, -1);
    runInstr("illegal", 16'hA000, -1, -1);
    runInstr("nop", 16'h0000, -1, -1);
    runInstr("jmp", 16'h7055, -1, -1);

    // Reset during MEM_WR must cancel the write and clear the zero flag.
    runInstr("sub z1b", 16'h4000, 1, -1);
    runInstr("store cut", 16'h2077, -1, 5);
    runInstr("jz after rst", 16'h8010, -1, -1);

    for (int n = 0; n < 120; n++) begin
      w = {4'($urandom_range(0, 14)), 12'($urandom)};
      runInstr("rand", w, -1, ($urandom_range(0, 9) == 0) ? -2 : -1);
    end

    runInstr("halt", 16'hF000, -1, -1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 16'($urandom), 1'($urandom_range(0, 1)));
      checkOutput("halt hold", 4'd9, haltO);
    end
    doReset(1);
    runInstr("post halt", 16'h3001, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
